inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/inst_fetch_fifo.sv | 69 ++++++
 rtl/inst_fetch.sv | 136 +++++++++++++
 tb/tb_inst_fetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int FETCH_DEPTH = 2;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  // RUN issues requests; DRAIN swallows responses that belong to flushed fetches.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry synchronous FIFO with clear, used for fetch tags and fetched instructions.
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

  // Next-state: clear wins; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited requests to instruction memory, in-order
// response tagging with the request pc, and a 2-entry queue toward decode.
//
// Handshake: id_valid/id_ready transfer one {id_pc, id_inst} on a cycle where
// both are 1; while id_valid=1 and id_ready=0 the head is held unchanged.
// im_req/im_gnt likewise transfer one request on a cycle where both are 1.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                   sys_clk,
  input  logic                   rstn,
  input  logic [INST_ADDR_W-1:0] pc_addr,
  input  logic                   ce,
  output logic                   fetch_stall,
  output logic                   im_req,
  output logic [INST_ADDR_W-1:0] im_addr,
  input  logic                   im_gnt,
  input  logic                   im_rvalid,
  input  logic [INST_W-1:0]      im_rdata,
  output logic                   id_valid,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  input  logic                   id_ready,
  input  logic                   flush,
  output fetch_state_e           dbg_state
);

  fetch_state_e state_q, state_d;
  logic [1:0]   out_cnt_q, out_cnt_d;
  logic [1:0]   drop_cnt_q, drop_cnt_d;

  logic                   rst_active;
  logic [1:0]             q_cnt;
  logic [2:0]             credits;
  logic                   in_run, grant, rsp_hit, rsp_accept, id_pop;
  logic [INST_ADDR_W-1:0] tag_head;
  logic [63:0]            q_head;
  logic                   tag_full, tag_empty, q_full, q_empty;
  logic [1:0]             tag_count;
  logic                   fifo_status_unused;

  assign rst_active = (rstn == RST_ENABLE);
  assign in_run     = (state_q == ST_RUN);

  // Credits come from registered counts only, so a same-cycle pop or response
  // frees a slot one cycle later.
  assign credits = 3'(FETCH_DEPTH) - ({1'b0, out_cnt_q} + {1'b0, q_cnt});

  // Reset gates the combinational outputs so they drop without a clock edge.
  assign im_req      = ~rst_active & ce & in_run & (credits != 3'd0) & ~flush;
  assign im_addr     = pc_addr;
  assign grant       = im_req & im_gnt;
  assign fetch_stall = ~rst_active & ce & ~grant;

  // A response with nothing outstanding is stray; one in a flush cycle is dropped.
  assign rsp_hit    = im_rvalid & (out_cnt_q != 2'd0);
  assign rsp_accept = in_run & rsp_hit & ~flush;

  assign id_valid = (q_cnt != 2'd0);
  assign id_pop   = id_valid & id_ready;
  assign id_pc    = q_head[63:32];
  assign id_inst  = q_head[31:0];
  assign dbg_state = state_q;

  assign fifo_status_unused = ^{tag_full, tag_empty, tag_count, q_full, q_empty};

  fetch_fifo #(.W(INST_ADDR_W)) u_tag_fifo (
    .clk   (sys_clk),
    .rst   (rst_active),
    .clear (flush),
    .push  (grant),
    .pop   (rsp_accept),
    .wdata (pc_addr),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fetch_fifo #(.W(64)) u_inst_q (
    .clk   (sys_clk),
    .rst   (rst_active),
    .clear (flush),
    .push  (rsp_accept),
    .pop   (id_pop),
    .wdata ({tag_head, im_rdata}),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  // Next-state: track outstanding requests in RUN; on flush, count the
  // responses still owed and swallow them in DRAIN.
  always_comb begin
    state_d    = state_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          out_cnt_d  = 2'd0;
          drop_cnt_d = out_cnt_q - {1'b0, rsp_hit};
          if (drop_cnt_d != 2'd0) begin
            state_d = ST_DRAIN;
          end
        end else begin
          out_cnt_d = out_cnt_q + {1'b0, grant} - {1'b0, rsp_accept};
        end
      end
      ST_DRAIN: begin
        if (im_rvalid && (drop_cnt_q != 2'd0)) begin
          drop_cnt_d = drop_cnt_q - 2'd1;
          if (drop_cnt_q == 2'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn == RST_ENABLE) begin
      state_q    <= ST_RUN;
      out_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table vectors, directed corner sequences and a
// randomized run against a queue-level reference model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic         sys_clk = 1'b0;
  logic         rstn = 1'b1;
  logic [31:0]  pc_addr = '0;
  logic         ce = 1'b0;
  logic         fetch_stall;
  logic         im_req;
  logic [31:0]  im_addr;
  logic         im_gnt = 1'b0;
  logic         im_rvalid = 1'b0;
  logic [31:0]  im_rdata = '0;
  logic         id_valid;
  logic [31:0]  id_pc;
  logic [31:0]  id_inst;
  logic         id_ready = 1'b0;
  logic         flush = 1'b0;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owed responses to deliver, responses to discard, decode queue.
  logic [31:0] pend_m[$];
  int          drop_m;
  logic [63:0] exp_q[$];
  // Memory model: granted requests awaiting a response, with earliest response cycle.
  logic [31:0] mem_pc[$];
  int          mem_due[$];
  int          cyc;

  typedef struct {
    logic        ce;
    logic        gnt;
    logic        fl;
    logic [31:0] pc;
    logic        exp_req;
    logic        exp_stall;
  } vec_t;
  vec_t vecs[7];

  inst_fetch dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .pc_addr     (pc_addr),
    .ce          (ce),
    .fetch_stall (fetch_stall),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_gnt      (im_gnt),
    .im_rvalid   (im_rvalid),
    .im_rdata    (im_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_ready    (id_ready),
    .flush       (flush),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Apply one cycle of inputs at the falling edge, then settle.
  task automatic drive(input logic c, input logic [31:0] pc, input logic g, input logic rv,
                       input logic [31:0] rd, input logic rdy, input logic fl);
    @(negedge sys_clk);
    ce = c; pc_addr = pc; im_gnt = g; im_rvalid = rv; im_rdata = rd; id_ready = rdy; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    ce = 0; im_gnt = 0; im_rvalid = 0; id_ready = 0; flush = 0; pc_addr = '0; im_rdata = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rstn = 1'b0;
    pend_m.delete(); exp_q.delete(); mem_pc.delete(); mem_due.delete(); drop_m = 0;
  endtask

  task automatic run_random(input int n);
    logic exp_req, exp_stall, dut_grant, pop;
    logic [31:0] item;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      cyc++;
      ce        = ($urandom_range(0, 3) != 0);
      pc_addr   = $urandom & 32'hFFFF_FFFC;
      im_gnt    = ($urandom_range(0, 2) != 0);
      id_ready  = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      im_rvalid = (mem_pc.size() > 0) && (mem_due[0] <= cyc) && ($urandom_range(0, 3) != 0);
      im_rdata  = $urandom;
      #1;
      exp_req   = ce && (drop_m == 0) && ((pend_m.size() + exp_q.size()) < 2) && !flush;
      exp_stall = ce && !(exp_req && im_gnt);
      check("rnd_im_req", im_req, exp_req);
      check("rnd_fetch_stall", fetch_stall, exp_stall);
      check("rnd_im_addr", im_addr, pc_addr);
      check("rnd_id_valid", id_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) check("rnd_id_head", {id_pc, id_inst}, exp_q[0]);
      // memory side
      dut_grant = im_req && im_gnt;
      if (im_rvalid) begin
        void'(mem_pc.pop_front());
        void'(mem_due.pop_front());
      end
      if (dut_grant) begin
        mem_pc.push_back(pc_addr);
        mem_due.push_back(cyc + 1);
      end
      // reference model update for this clock edge
      pop = (exp_q.size() > 0) && id_ready;
      if (pop) void'(exp_q.pop_front());
      if (im_rvalid) begin
        if (drop_m > 0) drop_m--;
        else if (pend_m.size() > 0) begin
          item = pend_m.pop_front();
          if (!flush) exp_q.push_back({item, im_rdata});
        end
      end
      if (flush) begin
        exp_q.delete();
        drop_m += pend_m.size();
        pend_m.delete();
      end
      if (exp_req && im_gnt) pend_m.push_back(pc_addr);
    end
  endtask

  initial begin
    vecs[0] = '{ce: 1, gnt: 1, fl: 0, pc: 32'h100, exp_req: 1, exp_stall: 0};
    vecs[1] = '{ce: 1, gnt: 0, fl: 0, pc: 32'h104, exp_req: 1, exp_stall: 1};
    vecs[2] = '{ce: 0, gnt: 1, fl: 0, pc: 32'h108, exp_req: 0, exp_stall: 0};
    vecs[3] = '{ce: 0, gnt: 0, fl: 0, pc: 32'h10C, exp_req: 0, exp_stall: 0};
    vecs[4] = '{ce: 1, gnt: 1, fl: 1, pc: 32'h110, exp_req: 0, exp_stall: 1};
    vecs[5] = '{ce: 1, gnt: 0, fl: 1, pc: 32'h114, exp_req: 0, exp_stall: 1};
    vecs[6] = '{ce: 0, gnt: 1, fl: 1, pc: 32'h118, exp_req: 0, exp_stall: 0};
    cyc = 0;
    drop_m = 0;

    // Reset state, with fetch inputs active
    @(negedge sys_clk);
    ce = 1; im_gnt = 1; id_ready = 1; pc_addr = 32'h44;
    #1;
    check("rst_im_req", im_req, 0);
    check("rst_fetch_stall", fetch_stall, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_inst", id_inst, 0);
    check("rst_state", dbg_state, ST_RUN);

    // Table: request/stall from idle RUN state
    for (int i = 0; i < 7; i++) begin
      do_reset();
      drive(vecs[i].ce, vecs[i].pc, vecs[i].gnt, 0, 0, 1, vecs[i].fl);
      check($sformatf("vec%0d_im_req", i), im_req, vecs[i].exp_req);
      check($sformatf("vec%0d_fetch_stall", i), fetch_stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_im_addr", i), im_addr, vecs[i].pc);
    end

    // Minimum latency: grant N, rvalid N+1, id_valid N+2
    do_reset();
    drive(1, 32'h0, 1, 0, 0, 1, 0);
    check("lat_req", im_req, 1);
    check("lat_stall", fetch_stall, 0);
    drive(0, 32'h0, 0, 1, 32'hDEADBEEF, 1, 0);
    check("lat_valid_n1", id_valid, 0);
    drive(0, 32'h0, 0, 0, 0, 1, 0);
    check("lat_valid_n2", id_valid, 1);
    check("lat_pc", id_pc, 32'h0);
    check("lat_inst", id_inst, 32'hDEADBEEF);
    drive(0, 32'h0, 0, 0, 0, 1, 0);
    check("lat_popped", id_valid, 0);

    // Backpressure: two fetches, decode not ready
    do_reset();
    drive(1, 32'h0, 1, 0, 0, 0, 0);
    drive(1, 32'h4, 1, 0, 0, 0, 0);
    check("bp_req_second", im_req, 1);
    drive(1, 32'h8, 1, 1, 32'h1111_0000, 0, 0);
    check("bp_req_c2", im_req, 0);
    check("bp_stall_c2", fetch_stall, 1);
    drive(1, 32'h8, 1, 1, 32'h2222_0004, 0, 0);
    check("bp_req_c3", im_req, 0);
    check("bp_valid_c3", id_valid, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h8, 1, 0, 0, 0, 0);
      check("bp_req_hold", im_req, 0);
      check("bp_stall_hold", fetch_stall, 1);
      check("bp_head_hold", {id_pc, id_inst}, {32'h0, 32'h1111_0000});
    end
    drive(1, 32'h8, 0, 0, 0, 1, 0);
    check("bp_req_pop_cycle", im_req, 0);
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    check("bp_req_after_pop", im_req, 1);
    check("bp_stall_after_pop", fetch_stall, 1);
    check("bp_head_next", {id_pc, id_inst}, {32'h4, 32'h2222_0004});

    // No grant for 3 cycles, then a stray response
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h40, 0, 0, 0, 1, 0);
      check("ng_req", im_req, 1);
      check("ng_stall", fetch_stall, 1);
    end
    drive(0, 32'h40, 0, 1, 32'hBAD0_BAD0, 1, 0);
    check("ng_stall_ce0", fetch_stall, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h40, 0, 0, 0, 1, 0);
      check("ng_no_push", id_valid, 0);
    end

    // Flush with two outstanding; responses at +1 and +2 discarded
    do_reset();
    drive(1, 32'h10, 1, 0, 0, 1, 0);
    drive(1, 32'h14, 1, 0, 0, 1, 0);
    drive(0, 32'h0, 0, 0, 0, 1, 1);
    check("fl_req_flush", im_req, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h18, 1, 1, 32'hCAFE_0000 + i, 1, 0);
      check("fl_state_drain", dbg_state, ST_DRAIN);
      check("fl_req_drain", im_req, 0);
      check("fl_stall_drain", fetch_stall, 1);
      check("fl_valid_drain", id_valid, 0);
    end
    drive(0, 32'h0, 0, 0, 0, 1, 0);
    check("fl_state_run", dbg_state, ST_RUN);
    check("fl_valid_after", id_valid, 0);
    drive(0, 32'h0, 0, 0, 0, 1, 0);
    check("fl_valid_after2", id_valid, 0);

    // Flush coincident with the only response
    do_reset();
    drive(1, 32'h20, 1, 0, 0, 1, 0);
    drive(0, 32'h0, 0, 1, 32'h5555_AAAA, 1, 1);
    drive(1, 32'h24, 0, 0, 0, 1, 0);
    check("flr_state", dbg_state, ST_RUN);
    check("flr_req", im_req, 1);
    check("flr_valid", id_valid, 0);
    drive(0, 32'h0, 0, 0, 0, 1, 0);
    check("flr_valid2", id_valid, 0);

    // Asynchronous reset with a valid head and a request outstanding
    do_reset();
    drive(1, 32'h30, 1, 0, 0, 0, 0);
    drive(1, 32'h34, 1, 1, 32'h7777_0030, 0, 0);
    drive(1, 32'h38, 1, 0, 0, 0, 0);
    check("ar_valid_before", id_valid, 1);
    check("ar_stall_before", fetch_stall, 1);
    #2;
    rstn = 1'b1;
    #1;
    check("ar_valid", id_valid, 0);
    check("ar_pc", id_pc, 0);
    check("ar_inst", id_inst, 0);
    check("ar_req", im_req, 0);
    check("ar_stall", fetch_stall, 0);

    // Randomized traffic with a reset in the middle
    do_reset();
    run_random(400);
    do_reset();
    run_random(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
